// File: rtl/pkg_config.sv
// Shared configuration for the rv32i core: data width plus load/store
// unit encodings and controller states.
package pkg_config;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } lsu_funct3_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        CAP     = 3'd2,
        RMW_RD  = 3'd3,
        RMW_MRG = 3'd4,
        WR      = 3'd5,
        ERR     = 3'd6
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
// Store sizes share funct3[1:0] with loads (00 byte, 01 half, 10 word).
module lsu_lane_align
    import pkg_config::*;
(
    input  logic [DATA_WIDTH-1:0] rd_word,
    input  logic [1:0]            lane,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic [DATA_WIDTH-1:0] mrg_word
);

    logic [DATA_WIDTH-1:0] shifted_s;

    // Load path: move the addressed lane down to bit 0, then extend
    always_comb begin
        shifted_s = rd_word >> {lane, 3'b000};
        case (funct3)
            LB:      ld_data = {{(DATA_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
            LH:      ld_data = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
            LW:      ld_data = rd_word;
            LBU:     ld_data = {{(DATA_WIDTH-8){1'b0}}, shifted_s[7:0]};
            LHU:     ld_data = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
            default: ld_data = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Store path: replace only the target lane of the word read back
    always_comb begin
        mrg_word = rd_word;
        case (funct3[1:0])
            2'b00: begin
                case (lane)
                    2'b00:   mrg_word[7:0]   = st_data[7:0];
                    2'b01:   mrg_word[15:8]  = st_data[7:0];
                    2'b10:   mrg_word[23:16] = st_data[7:0];
                    2'b11:   mrg_word[31:24] = st_data[7:0];
                    default: mrg_word = rd_word;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    mrg_word[31:16] = st_data[15:0];
                end else begin
                    mrg_word[15:0] = st_data[15:0];
                end
            end
            2'b10:   mrg_word = st_data;
            default: mrg_word = rd_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller driving the word-wide data_memory port; sub-word
// stores run as read-modify-write, sub-word loads are extended.
module lsu_mem_ctrl
    import pkg_config::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_e            state_r, state_s;
    logic [2:0]            funct3_r, funct3_s;
    logic [1:0]            lane_r, lane_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic                  mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]     mem_addr_r, mem_addr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_r, mem_wdata_s;
    logic                  rsp_valid_r, rsp_valid_s;
    logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
    logic                  rsp_err_r, rsp_err_s;
    logic                  f3_ok_s, req_err_s;
    logic [DATA_WIDTH-1:0] ld_data_s, mrg_word_s;

    lsu_lane_align u_align (
        .rd_word  (mem_rdata_i),
        .lane     (lane_r),
        .funct3   (funct3_r),
        .st_data  (wdata_r),
        .ld_data  (ld_data_s),
        .mrg_word (mrg_word_s)
    );

    // Request legality: funct3 set, natural alignment, address inside memory
    always_comb begin
        case (req_funct3_i)
            LB, LH, LW: f3_ok_s = 1'b1;
            LBU, LHU:   f3_ok_s = ~req_we_i;
            default:    f3_ok_s = 1'b0;
        endcase
        req_err_s = ~f3_ok_s
                  | ((req_funct3_i[1:0] == 2'b01) & req_addr_i[0])
                  | ((req_funct3_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00))
                  | (|req_addr_i[DATA_WIDTH-1:ADDR_W]);
    end

    // Next-state and next-output logic
    always_comb begin
        state_s     = state_r;
        funct3_s    = funct3_r;
        lane_s      = lane_r;
        wdata_s     = wdata_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid_i) begin
                    funct3_s   = req_funct3_i;
                    lane_s     = req_addr_i[1:0];
                    wdata_s    = req_wdata_i;
                    mem_addr_s = {req_addr_i[ADDR_W-1:2], 2'b00};
                    if (req_err_s) begin
                        state_s = ERR;
                    end else if (!req_we_i) begin
                        state_s = RD;
                    end else if (req_funct3_i[1:0] == 2'b10) begin
                        // Full-word store goes straight to the port
                        mem_we_s    = 1'b1;
                        mem_wdata_s = req_wdata_i;
                        state_s     = WR;
                    end else begin
                        state_s = RMW_RD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD:      state_s = CAP;
            CAP: begin
                rsp_valid_s = 1'b1;
                rsp_rdata_s = ld_data_s;
                state_s     = IDLE;
            end
            RMW_RD:  state_s = RMW_MRG;
            RMW_MRG: begin
                mem_we_s    = 1'b1;
                mem_wdata_s = mrg_word_s;
                state_s     = WR;
            end
            WR: begin
                rsp_valid_s = 1'b1;
                rsp_rdata_s = {DATA_WIDTH{1'b0}};
                state_s     = IDLE;
            end
            ERR: begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = 1'b1;
                rsp_rdata_s = {DATA_WIDTH{1'b0}};
                state_s     = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any pending request
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            funct3_r    <= 3'b000;
            lane_r      <= 2'b00;
            wdata_r     <= {DATA_WIDTH{1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            funct3_r    <= funct3_s;
            lane_r      <= lane_s;
            wdata_r     <= wdata_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    assign req_ready_o = (state_r == IDLE);
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign mem_we_o    = mem_we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: a byte-array reference memory predicts
// every response and every memory write; monitors compare as they appear.
module tb_lsu_mem_ctrl;
    import pkg_config::*;

    localparam int MEM_SIZE = 1024;
    localparam int ADDR_W   = 10;
    localparam int NWORDS   = MEM_SIZE / 4;

    logic        clk = 1'b0;
    logic        rst_i, req_valid, req_ready, req_we, rsp_valid, rsp_err, mem_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata, rsp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    lsu_mem_ctrl #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // data_memory model: synchronous read, single word write enable
    logic [31:0] mem [NWORDS];
    logic        preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NWORDS; i++) mem[i] <= (i < 3) ? i : 32'd0;
        end else if (mem_we) begin
            mem[mem_addr[ADDR_W-1:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[ADDR_W-1:2]];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic err; logic [31:0] rdata; int unsigned acc; int unsigned lat; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    rsp_t exp_q[$];
    wr_t  wr_q[$];
    rsp_t mon_r;
    wr_t  mon_w;
    logic [7:0] ref_mem [MEM_SIZE];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, RV32I size/sign rules
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                         output int unsigned lat);
        int nb, a;
        logic legal;
        nb = 1 << f3[1:0];
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err = !legal || (addr >= MEM_SIZE) || ((addr % nb) != 0);
        rdata = 32'd0;
        lat = 1;
        if (!err) begin
            a = int'(addr);
            if (!we) begin
                for (int i = 0; i < nb; i++) rdata[8*i +: 8] = ref_mem[a+i];
                if (!f3[2] && nb < 4 && rdata[8*nb-1])
                    for (int i = 8*nb; i < 32; i++) rdata[i] = 1'b1;
                lat = 2;
            end else begin
                for (int i = 0; i < nb; i++) ref_mem[a+i] = wd[8*i +: 8];
                lat = (nb == 4) ? 1 : 3;
            end
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit track);
        int guard;
        rsp_t r;
        wr_t w;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        if (track) begin
            model(we, f3, addr, wd, r.err, r.rdata, r.lat);
            r.acc = cyc + 1;
            exp_q.push_back(r);
            if (we && !r.err) begin
                w.addr = addr & 32'hFFFF_FFFC;
                w.data = ref_word(int'(addr >> 2));
                wr_q.push_back(w);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending rsp=%0d wr=%0d required 0", exp_q.size(), wr_q.size());
            exp_q.delete(); wr_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: responses and memory writes against the predicted queues
    always @(negedge clk) begin
        if (!rst_i && !preload) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: rsp_valid=1 required 0");
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_r.err});
                    chk("rsp_rdata", rsp_rdata, mon_r.rdata);
                    chk("rsp_latency", cyc - mon_r.acc, mon_r.lat);
                end
            end
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_we: mem_we=1 addr=%h required 0", mem_addr);
                end else begin
                    mon_w = wr_q.pop_front();
                    chk("mem_addr", {22'd0, mem_addr}, mon_w.addr);
                    chk("mem_wdata", mem_wdata, mon_w.data);
                end
            end
        end
    end

    initial begin
        rst_i = 1'b1; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'h00;
        ref_mem[4] = 8'h01;
        ref_mem[8] = 8'h02;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        rst_i = 1'b0;

        issue(1'b0, 3'b010, 32'h8, 32'h0, 1'b1);
        wait_idle();
        issue(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        wait_idle();
        chk("word0_after_sw", mem[0], 32'hDEAD_BEEF);

        issue(1'b1, 3'b000, 32'h1, 32'h0000_0080, 1'b1);
        issue(1'b0, 3'b000, 32'h1, 32'h0, 1'b1);
        issue(1'b0, 3'b100, 32'h1, 32'h0, 1'b1);
        wait_idle();
        chk("word0_after_sb", mem[0], 32'hDEAD_80EF);

        issue(1'b1, 3'b001, 32'h6, 32'h1234_8001, 1'b1);
        issue(1'b0, 3'b001, 32'h6, 32'h0, 1'b1);
        issue(1'b0, 3'b101, 32'h6, 32'h0, 1'b1);
        wait_idle();
        chk("word1_after_sh", mem[1], 32'h8001_0001);

        issue(1'b0, 3'b010, 32'h2, 32'h0, 1'b1);
        issue(1'b1, 3'b001, 32'h3, 32'hFFFF_FFFF, 1'b1);
        issue(1'b0, 3'b010, 32'h400, 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h0, 32'h0, 1'b1);
        wait_idle();
        chk("word0_after_errs", mem[0], 32'hDEAD_80EF);
        chk("word1_after_errs", mem[1], 32'h8001_0001);
        chk("word2_after_errs", mem[2], 32'h0000_0002);

        // Reset sampled at edge k+2 of an SB must suppress the write and response
        issue(1'b1, 3'b000, 32'h0, 32'h0000_0055, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_rmw_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rmw_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_rmw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("word0_after_rst", mem[0], 32'hDEAD_80EF);

        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) f3 = 3'($urandom);
            else f3 = we ? 3'($urandom_range(0, 2)) : ($urandom_range(0, 1) == 0 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5)));
            if ($urandom_range(0, 9) == 0) addr = 32'($urandom_range(MEM_SIZE, 4 * MEM_SIZE));
            else addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(we, f3, addr, $urandom, 1'b1);
        end
        wait_idle();
        for (int w = 0; w < NWORDS; w++) chk("final_mem_word", mem[w], ref_word(w));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
